score_keeper: RTL and testbench



---
 rtl/score_keeper_pkg.sv | 14 +
 rtl/rise_detect.sv | 21 ++
 rtl/score_keeper.sv | 129 ++++++++++++
 tb/tb_score_keeper.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types and default constants for the score_keeper game-state stage.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int LIVES_INIT_D = 5;
    localparam int MULT_MAX_D   = 4;
    localparam int SCORE_MAX_D  = 999;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; the delay register resets to RESET_VAL.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_q <= RESET_VAL;
        else         r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/score_keeper.sv
// Game FSM, score/lives/multiplier and board_clear pulse generation.
// Optional best-score tracking is enabled by defining SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int LIVES_INIT = LIVES_INIT_D,
    parameter int MULT_MAX   = MULT_MAX_D,
    parameter int SCORE_W    = 10,
    parameter int SCORE_MAX  = SCORE_MAX_D
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic [2:0]         mult,
    output logic               playing,
    output logic               game_over,
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    output logic [SCORE_W-1:0] best_score,
`endif
    output logic               board_clear
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_lives;
    logic [2:0]         r_mult;
    logic               r_playing;
    logic               r_game_over;
    logic               r_board_clear;
    logic               w_start_rise;
    logic               w_load;
    logic               w_end;
    logic               w_hit_ok;
    logic               w_miss_ok;
    logic [SCORE_W:0]   w_sum;

    // Reset value 1: a start key held through reset release must not start a game.
    rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (start),
        .o_rise (w_start_rise)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // NOTE: defaulting every combinational output first prevents latch inference.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, OVER: if (w_start_rise) w_state_nxt = PLAY;
            PLAY:       if (miss && r_lives == 4'd1) w_state_nxt = OVER;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_end     = 1'b0;
        w_hit_ok  = 1'b0;
        w_miss_ok = 1'b0;
        case (r_state)
            IDLE, OVER: w_load = w_start_rise;
            PLAY: begin
                w_miss_ok = miss;
                w_hit_ok  = hit & ~miss;
                w_end     = miss && r_lives == 4'd1;
            end
            default: ;
        endcase
    end

    // One bit wider than the score so the saturation compare never sees a wrapped sum.
    assign w_sum = {1'b0, r_score} + (SCORE_W+1)'(r_mult);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_score       <= '0;
            r_lives       <= 4'(LIVES_INIT);
            r_mult        <= 3'd1;
            r_playing     <= 1'b0;
            r_game_over   <= 1'b0;
            r_board_clear <= 1'b0;
        end else begin
            r_playing     <= (w_state_nxt == PLAY);
            r_game_over   <= (w_state_nxt == OVER);
            r_board_clear <= w_load | w_end;
            if (w_load) begin
                r_score <= '0;
                r_lives <= 4'(LIVES_INIT);
                r_mult  <= 3'd1;
            end else if (w_miss_ok) begin
                r_mult  <= 3'd1;
                r_lives <= r_lives - 4'd1;
            end else if (w_hit_ok) begin
                if (w_sum > (SCORE_W+1)'(SCORE_MAX)) r_score <= SCORE_W'(SCORE_MAX);
                else                                 r_score <= w_sum[SCORE_W-1:0];
                if (r_mult < 3'(MULT_MAX)) r_mult <= r_mult + 3'd1;
            end
        end
    end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_best_score;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                             r_best_score <= '0;
        else if (w_end && r_score > r_best_score) r_best_score <= r_score;
    end

    assign best_score = r_best_score;
`endif

    assign score       = r_score;
    assign lives       = r_lives;
    assign mult        = r_mult;
    assign playing     = r_playing;
    assign game_over   = r_game_over;
    assign board_clear = r_board_clear;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: the driver queues hand-computed expectations,
// the monitor pops and compares one per clock. Best-score checks follow SCORE_KEEPER_HIGH_SCORE_EN.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       hit;
    logic       miss;
    logic [9:0] score;
    logic [3:0] lives;
    logic [2:0] mult;
    logic       playing;
    logic       game_over;
    logic       board_clear;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [9:0] best_score;
`endif

    typedef struct {
        logic [9:0] score;
        logic [3:0] lives;
        logic [2:0] mult;
        logic       play;
        logic       over;
        logic       bc;
        logic [9:0] best;
        string      tag;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] e_best   = '0;

    score_keeper dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .lives       (lives),
        .mult        (mult),
        .playing     (playing),
        .game_over   (game_over),
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        .best_score  (best_score),
`endif
        .board_clear (board_clear)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic s, input logic h, input logic m,
                        input int es, input int el, input int em,
                        input logic ep, input logic eo, input logic eb, input string tag);
        exp_t e;
        @(negedge clk);
        start = s;
        hit   = h;
        miss  = m;
        e.score = 10'(es);
        e.lives = 4'(el);
        e.mult  = 3'(em);
        e.play  = ep;
        e.over  = eo;
        e.bc    = eb;
        e.best  = e_best;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".score"}, 32'(score), 32'd0);
        check({tag, ".lives"}, 32'(lives), 32'd5);
        check({tag, ".mult"},  32'(mult), 32'd1);
        check({tag, ".play"},  32'(playing), 32'd0);
        check({tag, ".over"},  32'(game_over), 32'd0);
        check({tag, ".bc"},    32'(board_clear), 32'd0);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        check({tag, ".best"},  32'(best_score), 32'd0);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check({e.tag, ".score"}, 32'(score), 32'(e.score));
                check({e.tag, ".lives"}, 32'(lives), 32'(e.lives));
                check({e.tag, ".mult"},  32'(mult), 32'(e.mult));
                check({e.tag, ".play"},  32'(playing), 32'(e.play));
                check({e.tag, ".over"},  32'(game_over), 32'(e.over));
                check({e.tag, ".bc"},    32'(board_clear), 32'(e.bc));
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
                check({e.tag, ".best"},  32'(best_score), 32'(e.best));
`endif
            end
        end
    end

    int hs[6] = '{1, 3, 6, 10, 14, 18};
    int hm[6] = '{2, 3, 4, 4, 4, 4};

    initial begin
        resetn = 1'b0;
        start  = 1'b1;
        hit    = 1'b0;
        miss   = 1'b0;
        #25;
        check_reset_state("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Start held through reset release: no game start, pulses ignored in IDLE.
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, "idle_held");
        step(1, 1, 0, 0, 5, 1, 0, 0, 0, "idle_hit");
        step(0, 0, 1, 0, 5, 1, 0, 0, 0, "idle_miss");
        step(1, 0, 0, 0, 5, 1, 1, 0, 1, "startA");
        step(1, 0, 0, 0, 5, 1, 1, 0, 0, "startA_bc_off");

        // Game A: multiplier ramp and saturation at MULT_MAX.
        for (int i = 0; i < 6; i++) step(1, 1, 0, hs[i], 5, hm[i], 1, 0, 0, "hitA");
        step(1, 0, 1, 18, 4, 1, 1, 0, 0, "missA");
        step(1, 1, 0, 19, 4, 2, 1, 0, 0, "hitA_after_miss");
        step(0, 0, 0, 19, 4, 2, 1, 0, 0, "playA_start_low");
        step(1, 0, 0, 19, 4, 2, 1, 0, 0, "playA_restart_ignored");
        step(1, 0, 1, 19, 3, 1, 1, 0, 0, "missA2");
        step(1, 0, 1, 19, 2, 1, 1, 0, 0, "missA3");
        step(1, 1, 1, 19, 1, 1, 1, 0, 0, "hit_and_miss");
        e_best = 10'd19;
        step(1, 0, 1, 19, 0, 1, 0, 1, 1, "overA");
        step(1, 1, 0, 19, 0, 1, 0, 1, 0, "overA_hit");
        step(0, 0, 1, 19, 0, 1, 0, 1, 0, "overA_miss");
        step(1, 1, 0, 0, 5, 1, 1, 0, 1, "startB_with_hit");

        // Game B: climb to 997 with mult 4, then saturate at 999.
        step(1, 0, 0, 0, 5, 1, 1, 0, 0, "startB_bc_off");
        step(1, 1, 0, 1, 5, 2, 1, 0, 0, "hitB1");
        step(1, 1, 0, 3, 5, 3, 1, 0, 0, "hitB2");
        step(1, 1, 0, 6, 5, 4, 1, 0, 0, "hitB3");
        step(1, 0, 1, 6, 4, 1, 1, 0, 0, "missB1");
        step(1, 1, 0, 7, 4, 2, 1, 0, 0, "hitB4");
        step(1, 0, 1, 7, 3, 1, 1, 0, 0, "missB2");
        step(1, 1, 0, 8, 3, 2, 1, 0, 0, "hitB5");
        step(1, 1, 0, 10, 3, 3, 1, 0, 0, "hitB6");
        step(1, 1, 0, 13, 3, 4, 1, 0, 0, "hitB7");
        step(1, 1, 0, 17, 3, 4, 1, 0, 0, "hitB8");
        for (int k = 1; k <= 245; k++) step(1, 1, 0, 17 + 4 * k, 3, 4, 1, 0, 0, "climbB");
        step(1, 1, 0, 999, 3, 4, 1, 0, 0, "sat_997");
        step(1, 1, 0, 999, 3, 4, 1, 0, 0, "sat_hold");
        step(1, 0, 1, 999, 2, 1, 1, 0, 0, "missB3");
        step(1, 0, 1, 999, 1, 1, 1, 0, 0, "missB4");
        e_best = 10'd999;
        step(1, 0, 1, 999, 0, 1, 0, 1, 1, "overB");
        step(0, 0, 0, 999, 0, 1, 0, 1, 0, "overB_hold");

        // Game C: lower final score must not reduce the best score.
        step(1, 0, 0, 0, 5, 1, 1, 0, 1, "startC");
        step(1, 1, 0, 1, 5, 2, 1, 0, 0, "hitC");
        step(1, 0, 1, 1, 4, 1, 1, 0, 0, "missC1");
        step(1, 0, 1, 1, 3, 1, 1, 0, 0, "missC2");
        step(1, 0, 1, 1, 2, 1, 1, 0, 0, "missC3");
        step(1, 0, 1, 1, 1, 1, 1, 0, 0, "missC4");
        step(1, 0, 1, 1, 0, 1, 0, 1, 1, "overC");
        step(0, 0, 0, 1, 0, 1, 0, 1, 0, "overC_hold");

        // Game D: asynchronous reset mid-game with a hit pending.
        step(1, 0, 0, 0, 5, 1, 1, 0, 1, "startD");
        step(1, 1, 0, 1, 5, 2, 1, 0, 0, "hitD");
        @(negedge clk);
        hit = 1'b1;
        #3;
        resetn = 1'b0;
        e_best = '0;
        #1;
        check_reset_state("midgame_reset");
        @(negedge clk);
        hit    = 1'b0;
        start  = 1'b0;
        resetn = 1'b1;
        step(0, 0, 0, 0, 5, 1, 0, 0, 0, "post_reset_idle");
        step(1, 0, 0, 0, 5, 1, 1, 0, 1, "post_reset_start");
        step(1, 0, 0, 0, 5, 1, 1, 0, 0, "post_reset_bc_off");

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
